// File: rtl/receive.sv
// 8N1 UART receiver; byte is presented on stb/dat at the mid-stop-bit sample (about 9.5 bit times after the start edge).
// Holds stb/dat until rdy; a frame that completes while a byte is still held and no transfer occurs is dropped.
module receive #(
    parameter int  BAUDRATE  = 9600,
    parameter real FREQUENCY = 12e6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rdy,
    output logic       stb,
    output logic [7:0] dat
);

    localparam int CYCLES = int'(FREQUENCY / BAUDRATE);
    localparam int CW     = $clog2(CYCLES) + 1;
    localparam logic [CW-1:0] FULL = CW'(CYCLES);
    localparam logic [CW-1:0] HALF = CW'(CYCLES / 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          rxd_s;
    logic          expired;
    logic          xfer;
    logic          frame_ok;

    assign rxd_s = sync[1];

    // The counter is loaded with the wait length and the sample is taken on the edge where it reaches 1.
    always_comb begin
        expired  = (cnt <= CW'(1));
        xfer     = stb & rdy;
        frame_ok = (state == STOP) && expired && rxd_s;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            sync  <= 2'b11;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            stb   <= 1'b0;
            dat   <= '0;
        end else begin
            sync <= {sync[0], rxd};

            if (state != IDLE && !expired)
                cnt <= cnt - CW'(1);

            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state <= START;
                        cnt   <= HALF;
                    end
                end
                START: begin
                    if (expired) begin
                        if (!rxd_s) begin
                            state <= DATA;
                            cnt   <= FULL;
                            idx   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (expired) begin
                        shreg <= {rxd_s, shreg[7:1]};
                        idx   <= idx + 3'd1;
                        cnt   <= FULL;
                        if (idx == 3'd7)
                            state <= STOP;
                    end
                end
                STOP: begin
                    // A low stop bit is a framing error: frame_ok stays low and the byte is discarded.
                    if (expired)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (frame_ok && (!stb || xfer)) begin
                dat <= shreg;
                stb <= 1'b1;
            end else if (xfer) begin
                stb <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_receive.sv
`timescale 1ns/1ps
module tb_receive;

    // Clock scaled to 1.2 MHz so one bit is 125 clocks and the run stays short.
    localparam int CYC = 125;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic       rdy = 1'b0;
    logic       stb;
    logic [7:0] dat;

    int   checks    = 0;
    int   errors    = 0;
    int   rises     = 0;
    int   exp_rises = 0;
    logic stb_q     = 1'b0;

    receive #(.BAUDRATE(9600), .FREQUENCY(1.2e6)) dut (
        .clk (clk),
        .rst (rst),
        .rxd (rxd),
        .rdy (rdy),
        .stb (stb),
        .dat (dat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (stb === 1'b1 && stb_q !== 1'b1)
            rises++;
        stb_q = stb;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        tick(CYC);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CYC);
        end
        rxd = stop;
        tick(CYC);
        rxd = 1'b1;
        tick(2 * CYC);
    endtask

    task automatic take(input string tag, input logic [7:0] exp);
        int n;
        n = 0;
        while (stb !== 1'b1 && n < 3 * CYC) begin
            tick(1);
            n++;
        end
        chk({tag, " stb"}, {31'd0, stb}, 32'd1);
        chk({tag, " dat"}, {24'd0, dat}, {24'd0, exp});
        rdy = 1'b1;
        tick(1);
        rdy = 1'b0;
        chk({tag, " stb_after"}, {31'd0, stb}, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        tick(5);
        chk("reset stb", {31'd0, stb}, 32'd0);
        chk("reset dat", {24'd0, dat}, 32'h00);
        rst = 1'b1;
        tick(3 * CYC);

        send(8'h8F, 1'b1);
        exp_rises++;
        take("8F", 8'h8F);
        chk("8F rises", rises, exp_rises);

        send(8'hF8, 1'b1);
        exp_rises++;
        take("F8", 8'hF8);
        chk("F8 rises", rises, exp_rises);

        send(8'h55, 1'b1);
        exp_rises++;
        tick(3 * CYC);
        chk("55 hold stb", {31'd0, stb}, 32'd1);
        chk("55 hold dat", {24'd0, dat}, 32'h55);
        take("55", 8'h55);
        chk("55 rises", rises, exp_rises);

        rxd = 1'b0;
        tick(30);
        rxd = 1'b1;
        tick(3 * CYC);
        chk("glitch stb", {31'd0, stb}, 32'd0);
        chk("glitch rises", rises, exp_rises);
        send(8'hA3, 1'b1);
        exp_rises++;
        take("A3", 8'hA3);

        send(8'h3C, 1'b0);
        tick(2 * CYC);
        chk("framing stb", {31'd0, stb}, 32'd0);
        chk("framing rises", rises, exp_rises);
        send(8'h81, 1'b1);
        exp_rises++;
        take("81", 8'h81);

        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        exp_rises++;
        chk("overrun rises", rises, exp_rises);
        take("overrun", 8'h11);
        tick(CYC);
        chk("overrun no second", {31'd0, stb}, 32'd0);
        chk("overrun rises after", rises, exp_rises);

        rxd = 1'b0;
        tick(CYC);
        for (int i = 0; i < 4; i++) begin
            rxd = i[0];
            tick(CYC);
        end
        rst = 1'b0;
        rxd = 1'b1;
        tick(3);
        chk("midreset stb", {31'd0, stb}, 32'd0);
        chk("midreset dat", {24'd0, dat}, 32'h00);
        rst = 1'b1;
        tick(12 * CYC);
        chk("midreset rises", rises, exp_rises);

        send(8'h6B, 1'b1);
        exp_rises++;
        take("6B", 8'h6B);
        chk("final rises", rises, exp_rises);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
